// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one operand bit per cycle, LSB first; Done pulses WIDTH+1 cycles after the accepted Start.
// No backpressure: Start is ignored outside IDLE, so the minimum issue interval is WIDTH+2 cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;

  logic             s_bit, c_nxt, last_bit;
  logic [WIDTH-1:0] acc_nxt;

  assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign acc_nxt  = {s_bit, acc_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == SHIFT);
    Done = (state == DONE);
  end

  // Sum/Cout load only on the final shift edge, so an aborted run never touches them.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q   <= A;
            b_q   <= B;
            c_q   <= Cin;
            cnt_q <= '0;
            acc_q <= '0;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          acc_q <= acc_nxt;
          c_q   <= c_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            Sum  <= acc_nxt;
            Cout <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder against an integer-add reference, via a result queue.
module tb_serial_adder;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         Busy, Done, Cout;
  logic [W-1:0] Sum;

  int errors = 0;
  int checks = 0;
  logic [W:0] sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Start(Start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Busy (Busy),
    .Done (Done),
    .Sum  (Sum),
    .Cout (Cout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // One full operation: scramble changes operands every busy cycle,
  // poke re-asserts Start with other operands during SHIFT and during DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input bit scramble, input bit poke);
    int n;
    int busy_cnt;
    int both_hi;
    logic [W:0] exp;
    A = a; B = b; Cin = ci; Start = 1'b1;
    sb.push_back(ref_add(a, b, ci));
    tick();
    Start = 1'b0;
    n = 0; busy_cnt = 0; both_hi = 0;
    while (!Done && n < 4 * W) begin
      if (Busy) busy_cnt++;
      if (Busy && Done) both_hi++;
      if (scramble) begin
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      end
      if (poke) begin
        Start = (n == 2);
        A = ~a; B = ~b; Cin = ~ci;
      end
      tick();
      n++;
    end
    Start = 1'b0;
    check("done_timeout", 32'(n < 4 * W), 1);
    check("busy_cycles", busy_cnt, W);
    check("busy_done_overlap", both_hi, 0);
    check("busy_in_done", Busy, 0);
    check("sb_nonempty", 32'(sb.size() > 0), 1);
    exp = sb.pop_front();
    check("sum", Sum, exp[W-1:0]);
    check("cout", Cout, exp[W]);
    if (poke) begin
      Start = 1'b1; A = 8'hAA; B = 8'h55;
      tick();
      Start = 1'b0;
      check("start_in_done_ignored", Busy, 0);
    end else begin
      tick();
    end
    check("done_one_cycle", Done, 0);
    check("sum_hold", Sum, exp[W-1:0]);
    check("cout_hold", Cout, exp[W]);
  endtask

  initial begin
    int last;
    int ndone;
    int n;
    int done_seen;

    Rst = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);

    // Start coinciding with reset is discarded
    Rst = 1'b1; Start = 1'b1; A = 8'h05; B = 8'h05;
    tick();
    Rst = 1'b0; Start = 1'b0;
    check("start_with_rst_busy", Busy, 0);
    tick();
    check("start_with_rst_busy2", Busy, 0);
    check("start_with_rst_sum", Sum, 0);

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Idle cycles keep the last result
    repeat (3) tick();
    check("idle_hold_sum", Sum, 8'hFF);
    check("idle_hold_cout", Cout, 1);

    do_op(8'h21, 8'h43, 1'b1, 1'b0, 1'b1);

    // Abort during the 4th SHIFT cycle
    A = 8'h10; B = 8'h20; Cin = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", Busy, 1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_sum", Sum, 0);
    check("abort_cout", Cout, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done || Busy) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    // Start held high: accepted every WIDTH+2 cycles
    A = 8'h12; B = 8'h34; Cin = 1'b0; Start = 1'b1;
    last = -1; ndone = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (Done) begin
        check("b2b_sum", Sum, 8'h46);
        if (last >= 0) check("b2b_interval", i - last, W + 2);
        last = i;
        ndone++;
      end else if (ndone > 0) begin
        check("b2b_sum_stable", Sum, 8'h46);
      end
    end
    Start = 1'b0;
    check("b2b_done_count", ndone, 4);
    n = 0;
    while ((Busy || Done) && n < 40) begin
      tick();
      n++;
    end
    check("b2b_drain", 32'(Busy || Done), 0);

    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
    end

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
